// File: rtl/reg_wr_arbiter_if.sv
// Register-file write arbiter bus: two writeback requesters, the
// register-file write port and the hazard lookup pair.
interface reg_wr_arbiter_if;
    logic        a_valid;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic        a_ready;

    logic        b_valid;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    logic        b_ready;

    logic        write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;

    logic [4:0]  reg1;
    logic [4:0]  reg2;
    logic        hazard1;
    logic        hazard2;

    modport master (
        output a_valid, a_reg, a_data,
        output b_valid, b_reg, b_data,
        output reg1, reg2,
        input  a_ready, b_ready,
        input  write, write_reg, write_data,
        input  hazard1, hazard2
    );

    modport slave (
        input  a_valid, a_reg, a_data,
        input  b_valid, b_reg, b_data,
        input  reg1, reg2,
        output a_ready, b_ready,
        output write, write_reg, write_data,
        output hazard1, hazard2
    );
endinterface

// File: rtl/reg_wr_arbiter.sv
// Merges ALU (A) and load (B) writebacks into one register-file write
// port through two 2-deep FIFOs and a round-robin tie-breaker.
module reg_wr_arbiter (
    input  logic             clk,
    input  logic             reset,
    reg_wr_arbiter_if.slave  bus
);

    localparam logic PRIO_A = 1'b0;
    localparam logic PRIO_B = 1'b1;

    logic [36:0] a_mem_q [2];
    logic [36:0] a_mem_d [2];
    logic        a_wp_q, a_wp_d;
    logic        a_rp_q, a_rp_d;
    logic [1:0]  a_cnt_q, a_cnt_d;

    logic [36:0] b_mem_q [2];
    logic [36:0] b_mem_d [2];
    logic        b_wp_q, b_wp_d;
    logic        b_rp_q, b_rp_d;
    logic [1:0]  b_cnt_q, b_cnt_d;

    logic        prio_q, prio_d;
    logic        wr_q, wr_d;
    logic [4:0]  wr_reg_q, wr_reg_d;
    logic [31:0] wr_data_q, wr_data_d;

    logic        a_ready, b_ready;
    logic        a_push, b_push;
    logic        a_ne, b_ne;
    logic        gnt_a, gnt_b;
    logic [36:0] a_head, a_tail;
    logic [36:0] b_head, b_tail;

    assign a_ready = ~reset & (a_cnt_q < 2'd2);
    assign b_ready = ~reset & (b_cnt_q < 2'd2);

    // Writes to x0 complete the handshake but are dropped here.
    assign a_push = bus.a_valid & a_ready & (bus.a_reg != 5'd0);
    assign b_push = bus.b_valid & b_ready & (bus.b_reg != 5'd0);

    assign a_ne = (a_cnt_q != 2'd0);
    assign b_ne = (b_cnt_q != 2'd0);

    assign a_head = a_mem_q[a_rp_q];
    assign a_tail = a_mem_q[~a_rp_q];
    assign b_head = b_mem_q[b_rp_q];
    assign b_tail = b_mem_q[~b_rp_q];

    assign gnt_a = a_ne & (~b_ne | (prio_q == PRIO_A));
    assign gnt_b = b_ne & (~a_ne | (prio_q == PRIO_B));

    always_comb begin
        prio_d = prio_q;
        if (a_ne && b_ne) begin
            prio_d = gnt_a ? PRIO_B : PRIO_A;
        end
    end

    always_comb begin
        a_mem_d = a_mem_q;
        a_wp_d  = a_wp_q;
        a_rp_d  = a_rp_q;
        a_cnt_d = a_cnt_q;
        if (a_push) begin
            a_mem_d[a_wp_q] = {bus.a_reg, bus.a_data};
            a_wp_d          = ~a_wp_q;
        end
        if (gnt_a) begin
            a_rp_d = ~a_rp_q;
        end
        unique case ({a_push, gnt_a})
            2'b10:   a_cnt_d = a_cnt_q + 2'd1;
            2'b01:   a_cnt_d = a_cnt_q - 2'd1;
            default: a_cnt_d = a_cnt_q;
        endcase
    end

    always_comb begin
        b_mem_d = b_mem_q;
        b_wp_d  = b_wp_q;
        b_rp_d  = b_rp_q;
        b_cnt_d = b_cnt_q;
        if (b_push) begin
            b_mem_d[b_wp_q] = {bus.b_reg, bus.b_data};
            b_wp_d          = ~b_wp_q;
        end
        if (gnt_b) begin
            b_rp_d = ~b_rp_q;
        end
        unique case ({b_push, gnt_b})
            2'b10:   b_cnt_d = b_cnt_q + 2'd1;
            2'b01:   b_cnt_d = b_cnt_q - 2'd1;
            default: b_cnt_d = b_cnt_q;
        endcase
    end

    always_comb begin
        wr_d      = gnt_a | gnt_b;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        if (gnt_a) begin
            wr_reg_d  = a_head[36:32];
            wr_data_d = a_head[31:0];
        end else if (gnt_b) begin
            wr_reg_d  = b_head[36:32];
            wr_data_d = b_head[31:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_mem_q   <= '{default: '0};
            a_wp_q    <= 1'b0;
            a_rp_q    <= 1'b0;
            a_cnt_q   <= 2'd0;
            b_mem_q   <= '{default: '0};
            b_wp_q    <= 1'b0;
            b_rp_q    <= 1'b0;
            b_cnt_q   <= 2'd0;
            prio_q    <= PRIO_A;
            wr_q      <= 1'b0;
            wr_reg_q  <= 5'd0;
            wr_data_q <= 32'd0;
        end else begin
            a_mem_q   <= a_mem_d;
            a_wp_q    <= a_wp_d;
            a_rp_q    <= a_rp_d;
            a_cnt_q   <= a_cnt_d;
            b_mem_q   <= b_mem_d;
            b_wp_q    <= b_wp_d;
            b_rp_q    <= b_rp_d;
            b_cnt_q   <= b_cnt_d;
            prio_q    <= prio_d;
            wr_q      <= wr_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Head is live once count>=1, the other slot only when full.
    function automatic logic q_hit(
        input logic [4:0] r,
        input logic [4:0] h,
        input logic [4:0] t,
        input logic [1:0] cnt
    );
        return ((cnt != 2'd0) && (h == r)) || ((cnt == 2'd2) && (t == r));
    endfunction

    function automatic logic hit(input logic [4:0] r);
        return (r != 5'd0) &&
               (q_hit(r, a_head[36:32], a_tail[36:32], a_cnt_q) ||
                q_hit(r, b_head[36:32], b_tail[36:32], b_cnt_q) ||
                (wr_q && (wr_reg_q == r)));
    endfunction

    assign bus.a_ready    = a_ready;
    assign bus.b_ready    = b_ready;
    assign bus.write      = wr_q;
    assign bus.write_reg  = wr_reg_q;
    assign bus.write_data = wr_data_q;
    assign bus.hazard1    = hit(bus.reg1);
    assign bus.hazard2    = hit(bus.reg2);

endmodule
